// File: rtl/pixel_writer.sv
// pixel_writer
//   Queues plot requests {x, y, colour} in a small FIFO and drains them to a
//   framebuffer write port, one pixel per cycle whenever the port is free.
//   The word address is y*SCREEN_W + x (modulo 2^17), formed by shift-and-add.
//
// Parameters
//   FIFO_DEPTH  queued plot requests (power of two, 2..16)
//   SCREEN_W    visible width in pixels
//   SCREEN_H    visible height in pixels
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous, active-high reset
//   x, y, colour plot request (column, row, RGB colour)
//   vga_enable   request strobe, one pixel per high cycle
//   ready        FIFO can accept a request this cycle
//   mem_busy     framebuffer write port unavailable this cycle
//   mem_addr     framebuffer word address (0 when mem_we is low)
//   mem_data     framebuffer write colour (0 when mem_we is low)
//   mem_we       framebuffer write enable, one cycle per pixel
//   pixel_count  pixels written, saturating at 131071
//   overflow     sticky: a request arrived while ready was low
//   idle         FIFO empty and mem_we low
//
// Build option
//   PIXEL_CLIP_EN  when defined, entries with x >= SCREEN_W or y >= SCREEN_H
//                  are consumed without producing a write.
module pixel_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  colour,
  input  logic        vga_enable,
  output logic        ready,
  input  logic        mem_busy,
  output logic [16:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  output logic [16:0] pixel_count,
  output logic        overflow,
  output logic        idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [16:0] SCREEN_W_VEC = 17'(SCREEN_W);

  // Reject configurations the datapath widths cannot represent.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SCREEN_W < 1 || SCREEN_W > 512 || SCREEN_H < 1 || SCREEN_H > 256) begin : g_bad_params
    $error("pixel_writer: unsupported parameter set");
  end

  // FIFO storage and bookkeeping
  logic [19:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Output stage
  logic        mem_we_reg;
  logic [16:0] mem_addr_reg;
  logic [2:0]  mem_data_reg;
  logic [16:0] pixel_count_reg;
  logic        overflow_reg;

  logic        push, pop;
  logic [19:0] head;
  logic [8:0]  head_x;
  logic [7:0]  head_y;
  logic [2:0]  head_c;
  logic [16:0] head_addr;
  logic        in_range;
  logic        write_next;
  logic [16:0] mem_addr_next;
  logic [2:0]  mem_data_next;

  // ready depends only on occupancy: a full FIFO never accepts, even if a
  // pop happens on the same edge.
  assign ready = (count_reg < CNT_W'(FIFO_DEPTH));
  assign push  = vga_enable & ready;
  assign pop   = (count_reg != '0) & ~mem_busy;

  assign head   = fifo_mem[rd_ptr_reg];
  assign head_x = head[19:11];
  assign head_y = head[10:3];
  assign head_c = head[2:0];

  // y*SCREEN_W as a sum of shifted copies of y, one per set bit of SCREEN_W.
  logic [16:0] row_term [17];
  for (genvar gi = 0; gi < 17; gi++) begin : g_row_term
    assign row_term[gi] = SCREEN_W_VEC[gi] ? (17'(head_y) << gi) : 17'd0;
  end

  always_comb begin
    head_addr = 17'(head_x);
    for (int i = 0; i < 17; i++) begin
      head_addr = head_addr + row_term[i];
    end
  end

`ifdef PIXEL_CLIP_EN
  assign in_range = (32'(head_x) < SCREEN_W) && (32'(head_y) < SCREEN_H);
`else
  assign in_range = 1'b1;
`endif

  // Address and data are forced to zero whenever no write is presented.
  always_comb begin
    write_next    = pop & in_range;
    mem_addr_next = 17'd0;
    mem_data_next = 3'd0;
    if (write_next) begin
      mem_addr_next = head_addr;
      mem_data_next = head_c;
    end
  end

  // Storage has no reset; the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr_reg] <= {x, y, colour};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= 17'd0;
      mem_data_reg    <= 3'd0;
      pixel_count_reg <= 17'd0;
      overflow_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg    <= count_reg + CNT_W'(push) - CNT_W'(pop);
      mem_we_reg   <= write_next;
      mem_addr_reg <= mem_addr_next;
      mem_data_reg <= mem_data_next;
      if (mem_we_reg && pixel_count_reg != 17'h1FFFF) begin
        pixel_count_reg <= pixel_count_reg + 17'd1;
      end
      if (vga_enable && !ready) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_data    = mem_data_reg;
  assign pixel_count = pixel_count_reg;
  assign overflow    = overflow_reg;
  assign idle        = (count_reg == '0) & ~mem_we_reg;

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of queued plot requests (power of two, 2..16).
REQ-002 SHALL have parameter SCREEN_W, default 320, the visible width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 240, the visible height in pixels.
REQ-004 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port x  input  9  plot column.
REQ-007 SHALL have port y  input  8  plot row.
REQ-008 SHALL have port colour  input  3  plot colour (RGB, 1 bit each).
REQ-009 SHALL have port vga_enable  input  1  plot request strobe, one pixel per high cycle.
REQ-010 SHALL have port ready  output  1  high when the FIFO can accept a request this cycle.
REQ-011 SHALL have port mem_busy  input  1  framebuffer write port unavailable this cycle.
REQ-012 SHALL have port mem_addr  output  17  framebuffer word address.
REQ-013 SHALL have port mem_data  output  3  framebuffer write colour.
REQ-014 SHALL have port mem_we  output  1  framebuffer write enable, one cycle per pixel.
REQ-015 SHALL have port pixel_count  output  17  pixels written to memory, saturating at 131071.
REQ-016 SHALL have port overflow  output  1  sticky: a request arrived while ready was low.
REQ-017 SHALL have port idle  output  1  FIFO empty and mem_we low.

Function
REQ-018 SHALL drive ready combinationally as (FIFO occupancy < FIFO_DEPTH); no same-cycle push-through when full.
REQ-019 SHALL push {x,y,colour} on a rising edge where vga_enable and ready are both high.
REQ-020 SHALL drop a request where vga_enable is high and ready is low, and set overflow to 1 until reset.
REQ-021 SHALL pop one entry on an edge where the FIFO is non-empty and mem_busy is low; push and pop on the same edge SHALL both take effect, with occupancy unchanged.
REQ-022 SHALL register the popped entry so that mem_we is high for exactly the cycle after the pop, with mem_addr = y*SCREEN_W + x computed modulo 2^17 using shift-and-add (y<<8 + y<<6 + x for the default).
REQ-023 SHALL give a latency of exactly 2 edges, from the accepting edge to mem_we high, when the FIFO is empty and mem_busy is low.
REQ-024 SHALL hold mem_addr and mem_data stable while mem_we is high, and SHALL drive both to 0 when mem_we is low.
REQ-025 SHALL increment pixel_count on every cycle in which mem_we is high, holding at 131071 with no wrap.
REQ-026 SHALL sustain a throughput of one pixel per cycle while mem_busy is low and the FIFO is non-empty.
REQ-027 SHALL stall pops while mem_busy is high, without losing or reordering entries.
REQ-028 SHALL write pixels to memory in acceptance order.
REQ-029 SHALL keep FIFO read and write pointers of log2(FIFO_DEPTH) bits with natural wrap-around.

Reset
REQ-030 SHALL, while reset is high at an edge, empty the FIFO and clear mem_we, mem_addr, mem_data, pixel_count and overflow to 0.
REQ-031 SHALL ignore vga_enable on any edge where reset is high.
REQ-032 SHALL drive ready and idle to 1 in the cycle after reset.
REQ-033 SHALL discard queued entries when reset is asserted mid-operation, and SHALL produce no mem_we in the cycle after reset.

Configuration
REQ-034 SHALL implement clipping when macro PIXEL_CLIP_EN is defined: a popped entry with x >= SCREEN_W or y >= SCREEN_H is consumed without asserting mem_we and without incrementing pixel_count.
REQ-035 SHALL, without PIXEL_CLIP_EN, write every popped entry with its address computed modulo 2^17.

Verification
REQ-036 SHALL cover: reset, then x=120, y=0, colour=7 with mem_busy=0 -> mem_we high 2 edges later, mem_addr=120, mem_data=7, pixel_count=1.
REQ-037 SHALL cover: 80 consecutive requests, x=120..199 at y=5, mem_busy=0 -> 80 back-to-back mem_we, addresses 1720..1799 in order.
REQ-038 SHALL cover: mem_busy=1 with 6 requests sent and FIFO_DEPTH=4 -> ready low after 4, overflow=1, and only 4 writes after mem_busy falls.
REQ-039 SHALL cover, with PIXEL_CLIP_EN: x=320, y=10 -> no mem_we, pixel_count unchanged, idle=1 after 2 cycles; without the macro -> mem_we with mem_addr=3520.
REQ-040 SHALL cover: x=319, y=239 -> mem_addr=76799.
REQ-041 SHALL cover: reset asserted with 3 entries queued -> no mem_we follows, and pixel_count=0, overflow=0, ready=1.
